// File: rtl/axi_rd_master_pkg.sv
// Shared AXI4 read-master types, constants and small arithmetic helpers.
package axi_rd_master_pkg;

  localparam int AXI_4K = 4096;

  typedef enum logic [2:0] {
    SIZE_1, SIZE_2, SIZE_4, SIZE_8, SIZE_16, SIZE_32, SIZE_64, SIZE_128
  } AxiSize_t;

  typedef enum logic [1:0] {BURST_FIXED, BURST_INCR, BURST_WRAP, BURST_RSVD} AxiBurst_t;

  typedef enum logic [1:0] {OKAY, EXOKAY, SLVERR, DECERR} AxiResp_t;

  typedef logic [3:0] AxiCache_t;
  // Bufferable + modifiable.
  localparam AxiCache_t CACHE_BUF_MOD = 4'b0011;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] bytes;
  } AxiMasterRdCtrl_t;

  typedef struct packed {
    AxiResp_t resp;
  } AxiMasterRdStatus_t;

  // Read-master FSM states; the state register is named 'state' in the top.
  typedef enum logic [2:0] {IDLE, CALC, AR, RD, DONE} AxiRdState_t;

  function automatic logic axiAccepted(input logic valid, input logic ready);
    return valid && ready;
  endfunction

  // EXOKAY counts as success for a single-ID non-exclusive master.
  function automatic logic axiSuccess(input logic [1:0] resp);
    return (resp == OKAY) || (resp == EXOKAY);
  endfunction

  // Byte count to beat count, rounded up.
  function automatic logic [16:0] bytes2beats(input logic [15:0] bytes, input AxiSize_t size);
    logic [16:0] sum;
    sum = {1'b0, bytes} + ((17'd1 << size) - 17'd1);
    return sum >> size;
  endfunction

  // Beats that fit between an aligned address and the next 4 KB boundary.
  function automatic logic [12:0] beatsTo4k(input logic [31:0] addr, input AxiSize_t size);
    logic [12:0] room;
    room = 13'(AXI_4K) - {1'b0, addr[11:0]};
    return room >> size;
  endfunction

endpackage

// File: rtl/axi_rd_master_splitter.sv
// Combinational burst sizing: how many beats the next burst may carry and
// where the burst after it starts.
module axi_burst_splitter
  import axi_rd_master_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic [31:0] addr,
  input  logic [16:0] beats_left,
  output logic [8:0]  len,
  output logic [31:0] next_addr
);

  localparam int       BPB  = DATA_W / 8;
  localparam AxiSize_t SIZE = AxiSize_t'(3'($clog2(BPB)));

  logic [16:0] cand;
  logic [12:0] to4k;

  // len = min(beats_left, MAX_BURST, beats to the 4 KB boundary).
  always_comb begin
    to4k = beatsTo4k(addr, SIZE);
    cand = beats_left;
    if (17'(MAX_BURST) < cand) cand = 17'(MAX_BURST);
    if ({4'b0, to4k} < cand) cand = {4'b0, to4k};
    len       = cand[8:0];
    next_addr = addr + (32'(len) << SIZE);
  end

endmodule

// File: rtl/axi_rd_master.sv
// Single-ID AXI4 read master: splits a byte-range request into 4 KB-safe INCR
// bursts, streams R data straight to the consumer and reports a final status.
//
// Handshake rule for every channel (ctrl, AR, R, dout, status): a transfer
// happens on the rising edge where valid && ready; a valid source holds its
// payload stable until that edge.
module axi_rd_master
  import axi_rd_master_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int ID_W      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  AxiMasterRdCtrl_t   ctrl,
  input  logic               ctrl_valid,
  output logic               ctrl_ready,
  output AxiMasterRdStatus_t status,
  output logic               status_valid,
  output logic [ID_W-1:0]    m_arid,
  output logic [31:0]        m_araddr,
  output logic [7:0]         m_arlen,
  output logic [2:0]         m_arsize,
  output logic [1:0]         m_arburst,
  output logic [3:0]         m_arcache,
  output logic               m_arvalid,
  input  logic               m_arready,
  input  logic [DATA_W-1:0]  m_rdata,
  input  logic [1:0]         m_rresp,
  input  logic               m_rlast,
  input  logic               m_rvalid,
  output logic               m_rready,
  output logic [DATA_W-1:0]  dout_data,
  output logic               dout_last,
  output logic               dout_valid,
  input  logic               dout_ready
);

  localparam int       BPB  = DATA_W / 8;
  localparam AxiSize_t SIZE = AxiSize_t'(3'($clog2(BPB)));

  AxiRdState_t state, state_next;
  logic [31:0] addr_q, next_addr_q, araddr_q;
  logic [16:0] beats_left;
  logic [7:0]  arlen_q;
  logic        last_burst_q, err_q, outst_q;
  AxiResp_t    resp_q;

  logic [8:0]  split_len;
  logic [31:0] split_next;
  logic        ctrl_hs, ar_hs, r_hs, beat_err, misaligned;

  axi_burst_splitter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) u_splitter (
    .addr       (addr_q),
    .beats_left (beats_left),
    .len        (split_len),
    .next_addr  (split_next)
  );

  assign m_arid    = '0;
  assign m_arsize  = SIZE;
  assign m_arburst = BURST_INCR;
  assign m_arcache = CACHE_BUF_MOD;

  assign ctrl_hs    = axiAccepted(ctrl_valid, ctrl_ready);
  assign ar_hs      = axiAccepted(m_arvalid, m_arready);
  assign r_hs       = axiAccepted(m_rvalid, m_rready);
  assign beat_err   = r_hs && !axiSuccess(m_rresp);
  assign misaligned = (ctrl.addr & 32'(BPB - 1)) != 32'd0;

  // State register plus request/burst bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      next_addr_q  <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      beats_left   <= '0;
      last_burst_q <= 1'b0;
      err_q        <= 1'b0;
      outst_q      <= 1'b0;
      resp_q       <= OKAY;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (ctrl_hs) begin
          addr_q     <= ctrl.addr;
          beats_left <= bytes2beats(ctrl.bytes, SIZE);
          err_q      <= 1'b0;
          resp_q     <= (ctrl.bytes != 16'd0 && misaligned) ? SLVERR : OKAY;
        end
        CALC: begin
          araddr_q     <= addr_q;
          arlen_q      <= 8'(split_len - 9'd1);
          next_addr_q  <= split_next;
          // The burst that exhausts the request carries dout_last.
          last_burst_q <= (17'(split_len) == beats_left);
        end
        RD: begin
          if (r_hs) beats_left <= beats_left - 17'd1;
          if (beat_err && !err_q) begin
            err_q  <= 1'b1;
            resp_q <= AxiResp_t'(m_rresp);
          end
          if (r_hs && m_rlast) addr_q <= next_addr_q;
        end
        default: ;
      endcase
      if (ar_hs) outst_q <= 1'b1;
      else if (r_hs && m_rlast) outst_q <= 1'b0;
    end
  end

  // Next state and all handshake outputs.
  always_comb begin
    state_next   = state;
    ctrl_ready   = 1'b0;
    m_arvalid    = 1'b0;
    m_rready     = 1'b0;
    dout_valid   = 1'b0;
    dout_last    = 1'b0;
    status_valid = 1'b0;
    case (state)
      IDLE: begin
        ctrl_ready = !rst;
        if (ctrl_hs) state_next = (ctrl.bytes == 16'd0 || misaligned) ? DONE : CALC;
      end
      CALC: state_next = AR;
      AR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_next = RD;
      end
      RD: begin
        m_rready   = dout_ready;
        dout_valid = m_rvalid;
        dout_last  = m_rvalid && m_rlast && last_burst_q;
        if (r_hs && m_rlast)
          state_next = (beats_left <= 17'd1 || err_q || beat_err) ? DONE : CALC;
      end
      DONE: begin
        status_valid = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign m_araddr    = araddr_q;
  assign m_arlen     = arlen_q;
  assign dout_data   = m_rdata;
  assign status.resp = resp_q;

  a_ar_stable: assert property (@(posedge clk) disable iff (rst)
    m_arvalid && !m_arready |=> m_arvalid && $stable(m_araddr) && $stable(m_arlen));
  a_no_4k_cross: assert property (@(posedge clk) disable iff (rst)
    m_arvalid |-> (32'(m_araddr[11:0]) + ((32'(m_arlen) + 32'd1) << SIZE)) <= 32'(AXI_4K));
  a_one_outstanding: assert property (@(posedge clk) disable iff (rst) ar_hs |-> !outst_q);
  a_rlast_matches_ar: assert property (@(posedge clk) disable iff (rst)
    (r_hs && m_rlast) |-> outst_q);
  a_all_bursts_closed: assert property (@(posedge clk) disable iff (rst)
    (state == DONE) |-> !outst_q);
  a_r_only_in_rd: assert property (@(posedge clk) disable iff (rst) m_rvalid |-> state == RD);

endmodule

// File: tb/tb_axi_rd_master.sv
// Self-checking bench for axi_rd_master: random-latency AXI slave model,
// scoreboard queues for AR, dout beats and status.
module tb_axi_rd_master;
  import axi_rd_master_pkg::*;

  localparam int DATA_W = 32, MAX_BURST = 16, ID_W = 1, BPB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  AxiMasterRdCtrl_t   ctrl;
  logic               ctrl_valid, ctrl_ready;
  AxiMasterRdStatus_t status;
  logic               status_valid;
  logic [ID_W-1:0]    m_arid;
  logic [31:0]        m_araddr;
  logic [7:0]         m_arlen;
  logic [2:0]         m_arsize;
  logic [1:0]         m_arburst;
  logic [3:0]         m_arcache;
  logic               m_arvalid, m_arready;
  logic [DATA_W-1:0]  m_rdata;
  logic [1:0]         m_rresp;
  logic               m_rlast, m_rvalid, m_rready;
  logic [DATA_W-1:0]  dout_data;
  logic               dout_last, dout_valid, dout_ready;

  axi_rd_master #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .status(status), .status_valid(status_valid), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arcache(m_arcache),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready), .dout_data(dout_data),
    .dout_last(dout_last), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0, n_fail = 0;
  logic [DATA_W:0] exp_q[$];          // {last, data}
  logic [31:0]     exp_ar_addr_q[$];
  logic [7:0]      exp_ar_len_q[$];
  logic [1:0]      exp_status_q[$];
  int beats_seen = 0;
  int status_cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic flush();
    exp_q.delete(); exp_ar_addr_q.delete(); exp_ar_len_q.delete(); exp_status_q.delete();
  endtask

  // Reference model: burst split, beat stream and final response.
  task automatic model_req(input logic [31:0] addr, input logic [15:0] bytes,
                           input logic [31:0] eaddr);
    int beats, room, len;
    logic [31:0] a, ba;
    bit err;
    beats = (int'(bytes) + BPB - 1) / BPB;
    a = addr;
    err = 0;
    if (bytes == 16'd0) begin exp_status_q.push_back(2'b00); return; end
    if (addr % BPB != 0) begin exp_status_q.push_back(2'b10); return; end
    while (beats > 0 && !err) begin
      room = (4096 - int'(a[11:0])) / BPB;
      len = beats;
      if (len > MAX_BURST) len = MAX_BURST;
      if (len > room) len = room;
      exp_ar_addr_q.push_back(a);
      exp_ar_len_q.push_back(8'(len - 1));
      for (int i = 0; i < len; i++) begin
        ba = a + 32'(i * BPB);
        exp_q.push_back({(len == beats && i == len - 1), pat(ba)});
        if (ba == eaddr) err = 1;
      end
      beats -= len;
      a = a + 32'(len * BPB);
    end
    exp_status_q.push_back(err ? 2'b10 : 2'b00);
  endtask

  // ---------------- AXI slave model ----------------
  logic [31:0] err_addr;
  logic [31:0] sl_addr_q[$];
  int          sl_len_q[$];
  bit          r_active, ar_hs_s, r_hs_s;
  logic [31:0] r_addr;
  int          r_rem;

  initial begin
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 0;
    r_active = 0; r_addr = '0; r_rem = 0;
    forever begin
      @(negedge clk);
      ar_hs_s = m_arvalid && m_arready && !rst;
      r_hs_s  = m_rvalid && m_rready && !rst;
      if (ar_hs_s) begin
        sl_addr_q.push_back(m_araddr);
        sl_len_q.push_back(int'(m_arlen) + 1);
      end
      @(posedge clk); #1;
      if (rst) begin
        sl_addr_q.delete(); sl_len_q.delete();
        r_active = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0;
        continue;
      end
      if (r_hs_s) begin
        r_addr += BPB;
        r_rem--;
        if (r_rem == 0) r_active = 0;
      end
      if (!r_active && sl_addr_q.size() > 0) begin
        r_addr = sl_addr_q.pop_front();
        r_rem  = sl_len_q.pop_front();
        r_active = 1;
      end
      m_arready = ($urandom_range(0, 2) != 0);
      if (r_active) begin
        if (!(m_rvalid && !r_hs_s)) m_rvalid = ($urandom_range(0, 3) != 0);
        m_rdata = pat(r_addr);
        m_rlast = (r_rem == 1);
        m_rresp = (r_addr == err_addr) ? 2'b10 : 2'b00;
      end else begin
        m_rvalid = 0;
        m_rlast  = 0;
      end
    end
  end

  // ---------------- consumer ready driver ----------------
  int ready_mode = 0;  // 0: always ready, 1: toggle, 2: random
  initial begin
    dout_ready = 1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       dout_ready = !dout_ready;
        2:       dout_ready = ($urandom_range(0, 1) != 0);
        default: dout_ready = 1;
      endcase
    end
  end

  // ---------------- output monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_arvalid && m_arready) begin
          check("ar_expected", 64'(exp_ar_addr_q.size() > 0), 1);
          if (exp_ar_addr_q.size() > 0) begin
            check("araddr", m_araddr, exp_ar_addr_q.pop_front());
            check("arlen", m_arlen, exp_ar_len_q.pop_front());
            check("arsize", m_arsize, SIZE_4);
            check("arburst", m_arburst, BURST_INCR);
            check("arcache", m_arcache, 4'b0011);
            check("arid", m_arid, 0);
          end
        end
        if (m_rvalid) check("rready_mirror", m_rready, dout_ready);
        if (dout_valid && dout_ready) begin
          beats_seen++;
          check("beat_expected", 64'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            logic [DATA_W:0] e;
            e = exp_q.pop_front();
            check("dout_data", dout_data, e[DATA_W-1:0]);
            check("dout_last", dout_last, e[DATA_W]);
          end
        end
        if (status_valid) begin
          status_cyc = cyc;
          check("status_expected", 64'(exp_status_q.size() > 0), 1);
          if (exp_status_q.size() > 0) check("status_resp", status.resp, exp_status_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic accept_req(input logic [31:0] addr, input logic [15:0] bytes, output int acc_cyc);
    bit ok;
    @(posedge clk); #1;
    ctrl.addr = addr; ctrl.bytes = bytes; ctrl_valid = 1;
    ok = 0;
    acc_cyc = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (ctrl_ready) begin ok = 1; acc_cyc = cyc; end
    end
    check("ctrl_accept", 64'(ok), 1);
    @(posedge clk); #1;
    ctrl_valid = 0;
  endtask

  task automatic run_req(input logic [31:0] addr, input logic [15:0] bytes,
                         input logic [31:0] eaddr, output int lat);
    int acc_cyc;
    model_req(addr, bytes, eaddr);
    err_addr = eaddr;
    accept_req(addr, bytes, acc_cyc);
    for (int k = 0; k < 3000 && exp_status_q.size() != 0; k++) @(negedge clk);
    check("status_seen", 64'(exp_status_q.size() == 0), 1);
    lat = status_cyc - acc_cyc;
    check("beats_drained", exp_q.size(), 0);
    check("ars_issued", exp_ar_addr_q.size(), 0);
    flush();
    repeat (2) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, acc_cyc, start_beats;
    logic [31:0] a;
    rst = 1; ctrl = '0; ctrl_valid = 0; err_addr = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl_ready", ctrl_ready, 0);
    check("rst_status_valid", status_valid, 0);
    check("rst_status_resp", status.resp, OKAY);
    check("rst_arvalid", m_arvalid, 0);
    check("rst_araddr", m_araddr, 0);
    check("rst_arlen", m_arlen, 0);
    check("rst_rready", m_rready, 0);
    check("rst_dout_valid", dout_valid, 0);
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    check("post_rst_ctrl_ready", ctrl_ready, 1);

    run_req(32'h0000_1000, 16'd64, 32'hFFFF_FFFF, lat);   // single 16-beat burst
    run_req(32'h0000_0FF0, 16'd64, 32'hFFFF_FFFF, lat);   // split at 4 KB
    run_req(32'h0000_2000, 16'd10, 32'hFFFF_FFFF, lat);   // rounded up to 3 beats
    run_req(32'h0000_2000, 16'd0,  32'hFFFF_FFFF, lat);   // empty request
    check("zero_len_latency", lat, 1);
    run_req(32'h0000_2002, 16'd8,  32'hFFFF_FFFF, lat);   // misaligned
    check("misaligned_latency", lat, 1);
    run_req(32'h0000_3000, 16'd128, 32'h0000_3010, lat);  // SLVERR on beat 5
    run_req(32'hFFFF_FFF0, 16'd64, 32'hFFFF_FFFF, lat);   // address wraps through 0

    ready_mode = 2;
    for (int n = 0; n < 6; n++) begin
      a = 32'h0002_0000 + 32'($urandom_range(0, 7)) * 32'd4096 - 32'($urandom_range(1, 40)) * 32'd4;
      run_req(a, 16'($urandom_range(1, 400)), 32'hFFFF_FFFF, lat);
    end

    // Toggling consumer, then reset in the middle of a burst.
    ready_mode = 1;
    model_req(32'h0000_4000, 16'd128, 32'hFFFF_FFFF);
    err_addr = 32'hFFFF_FFFF;
    start_beats = beats_seen;
    accept_req(32'h0000_4000, 16'd128, acc_cyc);
    for (int k = 0; k < 2000 && beats_seen < start_beats + 10; k++) @(negedge clk);
    check("beats_before_rst", 64'(beats_seen >= start_beats + 10), 1);
    @(posedge clk); #1; rst = 1;
    flush();
    repeat (2) @(negedge clk);
    check("mid_rst_ctrl_ready", ctrl_ready, 0);
    check("mid_rst_arvalid", m_arvalid, 0);
    check("mid_rst_rready", m_rready, 0);
    check("mid_rst_dout_valid", dout_valid, 0);
    check("mid_rst_status_valid", status_valid, 0);
    check("mid_rst_araddr", m_araddr, 0);
    check("mid_rst_arlen", m_arlen, 0);
    check("mid_rst_status_resp", status.resp, OKAY);
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    check("after_rst_ctrl_ready", ctrl_ready, 1);
    ready_mode = 0;
    run_req(32'h0000_5000, 16'd32, 32'hFFFF_FFFF, lat);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
